// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the 8-way round-robin arbiter.
//   N_REQ   : number of requesters
//   IDX_W   : width of a requester index
//   state_t : IDLE (no grant held) / BUSY (one grant held)
package arb_pkg;
    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;
endpackage

// File: rtl/rr_pick8.sv
// Combinational rotating-priority picker.
// Ports:
//   req    : request vector
//   ptr    : highest-priority index; search goes upward from ptr, wrapping 7->0
//   onehot : one-hot of the selected requester (zero when none)
//   idx    : binary index of the selected requester (zero when none)
//   any    : at least one request present
module rr_pick8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    logic [IDX_W-1:0] cand;

    // Scan from lowest priority (ptr+7) to highest (ptr+0); the last hit wins,
    // so the first set bit at or after ptr is selected. The 3-bit add wraps.
    always_comb begin
        idx  = '0;
        cand = '0;
        any  = |req;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + IDX_W'(k);
            if (req[cand]) idx = cand;
        end
        onehot = any ? (N_REQ'(1) << idx) : '0;
    end
endmodule

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with hold-until-release grants.
// Ports:
//   Clk        : clock, rising edge
//   Reset      : synchronous active-high reset
//   Req[7:0]   : request vector
//   Done       : current owner releases its grant
//   Grant[7:0] : registered one-hot grant (or zero)
//   GrantIdx   : registered binary index of the owner (zero when none)
//   GrantValid : high while a grant is held
//   Timeout    : one-cycle pulse after a grant was forcibly revoked
// Optional feature: define ARB_TIMEOUT_EN to add a hold watchdog that revokes
// a grant after TIMEOUT_CYCLES busy cycles. Without it Timeout is tied to 0.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [N_REQ-1:0]     Req,
    input  logic                 Done,
    output logic [N_REQ-1:0]     Grant,
    output logic [IDX_W-1:0]     GrantIdx,
    output logic                 GrantValid,
    output logic                 Timeout
);
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("rr_arbiter8: TIMEOUT_CYCLES must be 2..255");
    end

    state_t           state_q, state_n;
    logic [N_REQ-1:0] grant_q, grant_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic [IDX_W-1:0] ptr_q, ptr_n;
    logic             timeout_n;
    logic             rel;

    logic [N_REQ-1:0] pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    rr_pick8 u_pick (
        .req    (Req),
        .ptr    (ptr_q),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q, cnt_n;
    logic       timeout_q;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            grant_q <= grant_n;
            idx_q   <= idx_n;
            ptr_q   <= ptr_n;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= cnt_n;
            timeout_q <= timeout_n;
`endif
        end
    end

    always_comb begin
        state_n   = state_q;
        grant_n   = grant_q;
        idx_n     = idx_q;
        ptr_n     = ptr_q;
        timeout_n = 1'b0;
        rel       = Done | ~Req[idx_q];
`ifdef ARB_TIMEOUT_EN
        cnt_n = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                // Done is meaningless without an owner and is ignored here.
                if (pick_any) begin
                    state_n = BUSY;
                    grant_n = pick_oh;
                    idx_n   = pick_idx;
`ifdef ARB_TIMEOUT_EN
                    cnt_n = '0;
`endif
                end
            end
            BUSY: begin
                // A normal release takes precedence over the watchdog, so a
                // release landing on the last allowed cycle never flags Timeout.
                if (rel) begin
                    state_n = IDLE;
                    grant_n = '0;
                    idx_n   = '0;
                    ptr_n   = idx_q + IDX_W'(1);
`ifdef ARB_TIMEOUT_EN
                end else if (cnt_q == CNT_LAST) begin
                    state_n   = IDLE;
                    grant_n   = '0;
                    idx_n     = '0;
                    ptr_n     = idx_q + IDX_W'(1);
                    timeout_n = 1'b1;
                end else begin
                    cnt_n = cnt_q + 8'd1;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign Grant      = grant_q;
    assign GrantIdx   = idx_q;
    assign GrantValid = (state_q == BUSY);
`ifdef ARB_TIMEOUT_EN
    assign Timeout    = timeout_q;
`else
    assign Timeout    = timeout_n & 1'b0;
`endif
endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYCLES, default 16, maximum grant hold in cycles (legal 2..255; used only with ARB_TIMEOUT_EN).
REQ-002 SHALL provide port Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port Req  input  8  request vector; bit i = requester i wants the shared resource.
REQ-005 SHALL provide port Done  input  1  current owner releases grant this cycle.
REQ-006 SHALL provide port Grant  output  8  registered one-hot grant, or all zero.
REQ-007 SHALL provide port GrantIdx  output  3  registered binary index of granted requester; 3'b000 when none.
REQ-008 SHALL provide port GrantValid  output  1  high exactly when Grant is non-zero.
REQ-009 SHALL provide port Timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Function
REQ-010 SHALL implement two states: IDLE (no grant) and BUSY (one grant held).
REQ-011 In IDLE with Req != 0, SHALL select the first set bit at or after Ptr, searching upward with wrap 7->0, and enter BUSY; Grant, GrantIdx and GrantValid SHALL update at that edge (1-cycle request-to-grant latency).
REQ-012 In IDLE with Req == 0, SHALL stay in IDLE with all outputs zero.
REQ-013 In BUSY, SHALL hold Grant, GrantIdx and Ptr unchanged until release.
REQ-014 Release SHALL occur when Done = 1 or Req[GrantIdx] = 0; at that edge the block SHALL return to IDLE, clear Grant, GrantIdx and GrantValid, and set Ptr = (GrantIdx + 1) mod 8.
REQ-015 SHALL insert exactly one idle cycle between consecutive grants; no back-to-back handoff.
REQ-016 Done asserted in IDLE SHALL be ignored.
REQ-017 Requests from non-owners during BUSY SHALL NOT affect the current grant.
REQ-018 Ptr wrap-around: owner index 7 releasing SHALL set Ptr = 0.
REQ-019 Grant SHALL always be one-hot or zero, and GrantIdx SHALL always equal the binary encoding of Grant.

Reset
REQ-020 Reset = 1 at an edge SHALL force IDLE, Ptr = 0, Grant = 0, GrantIdx = 0, GrantValid = 0, Timeout = 0 and hold-counter = 0, overriding all other inputs including mid-grant.
REQ-021 The first arbitration after Reset deasserts SHALL take one cycle, with requester 0 at highest priority.

Configuration
REQ-022 Macro ARB_TIMEOUT_EN SHALL enable the watchdog: an 8-bit hold counter clears on grant and increments each BUSY cycle.
REQ-023 With ARB_TIMEOUT_EN, when the counter reaches TIMEOUT_CYCLES - 1 without release, the block SHALL release per REQ-014 at that edge and pulse Timeout for that one cycle.
REQ-024 With ARB_TIMEOUT_EN, if the counter reaches TIMEOUT_CYCLES - 1 in the same cycle as a normal release, the release SHALL be treated as normal and Timeout SHALL stay 0.
REQ-025 Without ARB_TIMEOUT_EN, the Timeout port SHALL remain present and be tied to 0, no counter logic SHALL be generated, and a grant SHALL be held indefinitely.

Structure
REQ-026 Package arb_pkg SHALL hold the constants N_REQ = 8 and IDX_W = 3 and the IDLE/BUSY state encoding.
REQ-027 Sub-module rr_pick8 SHALL be a combinational rotating priority picker (Req, Ptr -> one-hot, index, any) instantiated once; all registers SHALL live in rr_arbiter8.

Verification
REQ-028 Single request: after reset, Req = 8'h04 -> next cycle Grant = 8'h04, GrantIdx = 2, GrantValid = 1; Done pulse -> next cycle all zero, Ptr = 3.
REQ-029 Fairness: Req = 8'hFF held, Done pulsed every grant -> grant order is 0,1,2,...,7,0, with one idle cycle between each grant.
REQ-030 Wrap-around: owner 7 with Req = 8'h81 -> after release, next grant is 0; then Req = 8'h81 again -> next grant is 7.
REQ-031 Request drop: owner 5 deasserts Req[5] with Done = 0 -> grant released next edge, Timeout = 0.
REQ-032 Reset mid-grant: owner 3 in BUSY, Reset pulse -> outputs zero; with Req = 8'h18, next grant is 3 (Ptr = 0).
REQ-033 With ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 4: owner 1 never releases -> Grant drops after 4 BUSY cycles with a 1-cycle Timeout pulse; without the macro, the grant holds for 100+ cycles and Timeout stays 0.
